// File: rtl/uart_arb_pkg.sv
// Shared definitions for the two-source UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned MAX_LEN_DEF  = 32;
  localparam int unsigned WDOG_CYC_DEF = 1023;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_LOAD  = 3'd2,
    S_WBUSY = 3'd3,
    S_WDONE = 3'd4,
    S_NEXT  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

endpackage

// File: rtl/uart_tx_arb_rr_arb2.sv
// Two-way round-robin picker: a tie goes to the source not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick_c
);

  // One-hot pick; last=1 means source 1 was served most recently.
  always_comb begin
    pick_c = 2'b00;
    case (req)
      2'b01:   pick_c = 2'b01;
      2'b10:   pick_c = 2'b10;
      2'b11:   pick_c = last ? 2'b01 : 2'b10;
      default: pick_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uarttx between two message sources, streaming the granted
// source's bytes and pacing on the transmitter's busy flag.
// Optional busy-wait watchdog: define UART_ARB_WATCHDOG_EN.
import uart_arb_pkg::*;

module uart_tx_arb #(
  parameter  int unsigned MAX_LEN  = MAX_LEN_DEF,
  parameter  int unsigned WDOG_CYC = WDOG_CYC_DEF,
  localparam int unsigned IW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic [1:0]    req,
  input  logic [IW-1:0] len0,
  input  logic [IW-1:0] len1,
  input  logic [7:0]    rd_data0,
  input  logic [7:0]    rd_data1,
  output logic [1:0]    gnt,
  output logic [IW-1:0] rd_idx,
  output logic [1:0]    done,
  output logic [7:0]    txdata,
  output logic          wrsig,
  input  logic          idle,
  output logic          err
);

  state_t        state_q, state_d;
  logic [1:0]    gnt_d, done_d, pick_c;
  logic [IW-1:0] len_q, len_d, idx_d;
  logic [IW-1:0] len0_c, len1_c;
  logic [7:0]    txdata_d, rd_sel_c;
  logic          last_q, last_d, wrsig_d, err_d;

`ifdef UART_ARB_WATCHDOG_EN
  localparam int unsigned WW = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
`endif

  rr_arb2 u_rr (
    .req    (req),
    .last   (last_q),
    .pick_c (pick_c)
  );

  // Length clamp and granted-source byte mux.
  assign len0_c   = (len0 > IW'(MAX_LEN)) ? IW'(MAX_LEN) : len0;
  assign len1_c   = (len1 > IW'(MAX_LEN)) ? IW'(MAX_LEN) : len1;
  assign rd_sel_c = gnt[1] ? rd_data1 : rd_data0;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt;
    len_d    = len_q;
    idx_d    = rd_idx;
    last_d   = last_q;
    txdata_d = txdata;
    wrsig_d  = 1'b0;
    done_d   = 2'b00;
    err_d    = 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
    wd_cnt_d = wd_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d = S_GRANT;
          gnt_d   = pick_c;
          len_d   = pick_c[1] ? len1_c : len0_c;
          idx_d   = '0;
          last_d  = pick_c[1];
        end
      end
      S_GRANT: begin
        if (len_q == '0) begin
          state_d = S_FIN;
          done_d  = gnt;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        txdata_d = rd_sel_c;
        wrsig_d  = 1'b1;
        state_d  = S_WBUSY;
      end
      S_WBUSY: if (idle)  state_d = S_WDONE;
      S_WDONE: if (!idle) state_d = S_NEXT;
      S_NEXT: begin
        if (rd_idx == len_q - IW'(1)) begin
          state_d = S_FIN;
          done_d  = gnt;
        end else begin
          idx_d   = rd_idx + IW'(1);
          state_d = S_LOAD;
        end
      end
      S_FIN: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef UART_ARB_WATCHDOG_EN
    // A stuck busy flag costs the byte but never the rest of the message.
    if (state_q == S_LOAD) begin
      wd_cnt_d = '0;
    end else if (state_q == S_WBUSY || state_q == S_WDONE) begin
      if (wd_cnt_q == WW'(WDOG_CYC - 1)) begin
        err_d   = 1'b1;
        state_d = S_NEXT;
      end else begin
        wd_cnt_d = wd_cnt_q + WW'(1);
      end
    end
`endif
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      gnt     <= 2'b00;
      len_q   <= '0;
      rd_idx  <= '0;
      last_q  <= 1'b1;
      txdata  <= 8'h00;
      wrsig   <= 1'b0;
      done    <= 2'b00;
      err     <= 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
      wd_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      len_q   <= len_d;
      rd_idx  <= idx_d;
      last_q  <= last_d;
      txdata  <= txdata_d;
      wrsig   <= wrsig_d;
      done    <= done_d;
      err     <= err_d;
`ifdef UART_ARB_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Sequencer and round-robin arbiter that shares the single `uarttx` transmitter between two message sources, for example the periodic time report and an alarm/status report. Each source presents a message as an indexed byte array. The arbiter grants one source at a time and streams its bytes into `uarttx`. Pacing uses the transmitter's `idle` busy flag instead of a fixed wait count. It sits between the message builders and `uarttx`, clocked by the divided UART clock.

## Interface
- `MAX_LEN`, default 32: maximum message length in bytes; sets the index width `IW = $clog2(MAX_LEN+1)`.
- `WDOG_CYC`, default 1023: watchdog limit in clk cycles. Used only when `UART_ARB_WATCHDOG_EN` is defined.

- `clk`  in  1: clock (UART clock domain).
- `RSTn`  in  1: reset, synchronous, active-low.
- `req`  in  2: per-source send request. Level; sampled only while the arbiter is in IDLE.
- `len0`, `len1`  in  IW each: message length of source 0/1, range 0..MAX_LEN. Sampled at grant.
- `rd_data0`, `rd_data1`  in  8 each: byte of source 0/1 at `rd_idx`. Combinational from the source.
- `gnt`  out  2: one-hot grant. Held for the whole message.
- `rd_idx`  out  IW: byte index requested from the granted source.
- `done`  out  2: one-cycle pulse for the granted source at message end.
- `txdata`  out  8: byte to `uarttx` `datain`.
- `wrsig`  out  1: one-cycle send strobe to `uarttx`.
- `idle`  in  1: `uarttx` busy flag; 1 = transmitting.
- `err`  out  1: one-cycle watchdog pulse. Tied 0 when the watchdog is compiled out.

## Operation
- States and transitions:
  - IDLE: if `req` is nonzero, go to GRANT.
  - GRANT: if the latched length is 0, go to FIN; otherwise go to LOAD.
  - LOAD: go to WBUSY.
  - WBUSY: when `idle`=1, go to WDONE.
  - WDONE: when `idle`=0, go to NEXT.
  - NEXT: if `rd_idx` = len−1, go to FIN; otherwise increment `rd_idx` and go to LOAD.
  - FIN: go to IDLE.
- Arbitration in IDLE:
  - If only one request is set, grant that source.
  - If both are set, grant the source not served last. The `last` pointer resets to 1, so source 0 wins the first tie.
  - On entering GRANT: `gnt` is set, `len` is latched, `rd_idx` is set to 0, and `last` is updated.
- LOAD: registers `txdata` ← `rd_data` of the granted source and sets `wrsig`=1. `wrsig` clears on the next edge, so it is exactly one cycle wide.
- FIN: pulses `done[g]`; `gnt` clears on the exit edge. A source must hold its bytes stable while its `gnt` is set.
- Deasserting `req` mid-message is ignored; the message completes. A `req` held high after `done` is re-arbitrated in IDLE. With both sources requesting continuously, grants alternate.
- `len` = 0 is legal: grant, then `done` pulse, with no `wrsig`.
- `len` > MAX_LEN is clamped to MAX_LEN.
- Reset is honoured in every state and aborts any message in progress. No `done` pulse is issued for an aborted message.
- Reset values: `gnt`=0, `rd_idx`=0, `done`=0, `txdata`=0, `wrsig`=0, `err`=0, state=IDLE, `last`=1.

## Timing
- `req` is seen at edge E0, giving `gnt` at E1. `txdata` and `wrsig` are valid after E2; `wrsig` falls at E3.
- Each byte costs 4 cycles of overhead, plus the `uarttx` rise latency and the frame time.
- FIN to IDLE takes 1 cycle, so the minimum gap between messages is 2 cycles.
- `idle` can rise on the same edge that `wrsig` falls; WBUSY then exits after 1 cycle.

## Configuration
- `UART_ARB_WATCHDOG_EN` defined:
  - A counter clears on entry to WBUSY and counts while the FSM is in WBUSY or WDONE.
  - On reaching `WDOG_CYC`, the arbiter pulses `err` for 1 cycle and forces NEXT. The byte counts as sent, so the message continues.
- `UART_ARB_WATCHDOG_EN` undefined: no counter; WBUSY and WDONE wait indefinitely; `err` is tied 0.

## Structure
- Shared package `uart_arb_pkg`: state encoding (IDLE, GRANT, LOAD, WBUSY, WDONE, NEXT, FIN), `MAX_LEN` and `WDOG_CYC` defaults.
- Sub-module `rr_arb2`: combinational 2-way round-robin picker. Inputs `req`[1:0] and `last`; outputs a one-hot pick.
- Top level: FSM, index counter, length latch, data mux, and the watchdog under the macro.

## Test plan
- **Single message:** `req0`=1, `len0`=3, bytes "A","B","C", with a `uarttx` model (busy for 20 cycles, 2-cycle rise delay).
  - Expect 3 `wrsig` pulses with `txdata` 0x41, 0x42, 0x43.
  - Expect `done`=2'b01 once; `gnt` clears the cycle after `done`.
- **Simultaneous requests from reset:** `req`=2'b11, `len0`=`len1`=2.
  - Expect source 0 served fully, then source 1.
  - Expect grant order 01, 10, 01 while both requests stay high.
- **Zero length:** `len1`=0, `req1`=1.
  - Expect `gnt`=10, then `done`=10, within 3 cycles; no `wrsig`.
- **Reset mid-message:** `RSTn`=0 during the 2nd byte of 5.
  - Expect all outputs 0 and state IDLE on the next edge; no `done` pulse.
- **Watchdog:** with `UART_ARB_WATCHDOG_EN` defined, `idle` stuck at 0 and `WDOG_CYC`=15.
  - Expect an `err` pulse 15 cycles after each `wrsig`; the message completes with `done`.
- **Watchdog compiled out:** same stimulus without the macro.
  - Expect the FSM to stay in WBUSY, `err`=0, and no `done`.
